morse_char_decoder: RTL

//  Consumer of the 3-bit element stream from the Morse transmit/translate FSM.

---
 rtl/morse_char_decoder_if.sv | 22 ++
 rtl/morse_char_decoder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/morse_char_decoder_if.sv
// Element stream in, ASCII character stream out. The decoder takes the master side
// and the text sink / element source takes the slave side.
interface morse_char_decoder_if;
   logic [2:0] in_code;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;

   modport master (
      input  in_code,
      input  out_ready,
      output out_data,
      output out_valid
   );

   modport slave (
      output in_code,
      output out_ready,
      input  out_data,
      input  out_valid
   );
endinterface

// File: rtl/morse_char_decoder.sv
// Collects Morse dot/dash elements into a symbol, decodes it to uppercase ASCII on a
// character or word space, and queues the characters in a small output FIFO.
module morse_char_decoder #(
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_ELEMS  = 5
) (
   input  logic                              clk,
   input  logic                              rst,
   morse_char_decoder_if.master              bus,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
   output logic                              err_unknown,
   output logic                              ovf_err,
   input  logic                              clr_err
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = $clog2(MAX_ELEMS + 2);

   typedef enum logic {S_COLLECT, S_SPACE} state_t;

   state_t                 state, nxt_state;
   logic [LW-1:0]          len;
   logic [MAX_ELEMS-1:0]   sym;
   logic [PW-1:0]          wr_ptr, rd_ptr;
   logic [7:0]             mem [FIFO_DEPTH];

   logic       push, pop, push_ok, drop;
   logic       use_lookup, clr_sym, elem, illegal, unk_char;
   logic [7:0] push_char;
   logic [8:0] lk;

   // Length saturates one past the longest legal symbol so overlong stays overlong.
   function automatic logic [LW-1:0] len_sat_inc(input logic [LW-1:0] l);
      return (l == LW'(MAX_ELEMS + 1)) ? l : l + LW'(1);
   endfunction

   // Returns {matched, ascii}; first element sits in the highest of the len bits.
   function automatic logic [8:0] lookup(input logic [LW-1:0] l, input logic [MAX_ELEMS-1:0] s);
      logic [7:0] key;
      logic [7:0] ch;
      if (l == '0 || l > LW'(5)) return {1'b0, 8'h3F};
      key = {3'(l), 5'(s)};
      case (key)
         {3'd2, 5'b00001}: ch = 8'h41; // A
         {3'd4, 5'b01000}: ch = 8'h42; // B
         {3'd4, 5'b01010}: ch = 8'h43; // C
         {3'd3, 5'b00100}: ch = 8'h44; // D
         {3'd1, 5'b00000}: ch = 8'h45; // E
         {3'd4, 5'b00010}: ch = 8'h46; // F
         {3'd3, 5'b00110}: ch = 8'h47; // G
         {3'd4, 5'b00000}: ch = 8'h48; // H
         {3'd2, 5'b00000}: ch = 8'h49; // I
         {3'd4, 5'b00111}: ch = 8'h4A; // J
         {3'd3, 5'b00101}: ch = 8'h4B; // K
         {3'd4, 5'b00100}: ch = 8'h4C; // L
         {3'd2, 5'b00011}: ch = 8'h4D; // M
         {3'd2, 5'b00010}: ch = 8'h4E; // N
         {3'd3, 5'b00111}: ch = 8'h4F; // O
         {3'd4, 5'b00110}: ch = 8'h50; // P
         {3'd4, 5'b01101}: ch = 8'h51; // Q
         {3'd3, 5'b00010}: ch = 8'h52; // R
         {3'd3, 5'b00000}: ch = 8'h53; // S
         {3'd1, 5'b00001}: ch = 8'h54; // T
         {3'd3, 5'b00001}: ch = 8'h55; // U
         {3'd4, 5'b00001}: ch = 8'h56; // V
         {3'd3, 5'b00011}: ch = 8'h57; // W
         {3'd4, 5'b01001}: ch = 8'h58; // X
         {3'd4, 5'b01011}: ch = 8'h59; // Y
         {3'd4, 5'b01100}: ch = 8'h5A; // Z
         {3'd5, 5'b11111}: ch = 8'h30;
         {3'd5, 5'b01111}: ch = 8'h31;
         {3'd5, 5'b00111}: ch = 8'h32;
         {3'd5, 5'b00011}: ch = 8'h33;
         {3'd5, 5'b00001}: ch = 8'h34;
         {3'd5, 5'b00000}: ch = 8'h35;
         {3'd5, 5'b10000}: ch = 8'h36;
         {3'd5, 5'b11000}: ch = 8'h37;
         {3'd5, 5'b11100}: ch = 8'h38;
         {3'd5, 5'b11110}: ch = 8'h39;
         default:          return {1'b0, 8'h3F};
      endcase
      return {1'b1, ch};
   endfunction

   assign lk       = lookup(len, sym);
   assign elem     = (bus.in_code == 3'b001) || (bus.in_code == 3'b010);
   assign illegal  = bus.in_code >= 3'b101;
   assign unk_char = use_lookup && !lk[8];

   always_comb begin
      push       = 1'b0;
      use_lookup = 1'b0;
      clr_sym    = 1'b0;
      nxt_state  = state;
      case (state)
         S_COLLECT: begin
            if (bus.in_code == 3'b011 && len != '0) begin
               push       = 1'b1;
               use_lookup = 1'b1;
               clr_sym    = 1'b1;
            end else if (bus.in_code == 3'b100) begin
               push = 1'b1;
               if (len != '0) begin
                  use_lookup = 1'b1;
                  clr_sym    = 1'b1;
                  nxt_state  = S_SPACE;
               end
            end
         end
         default: begin
            push      = 1'b1;
            nxt_state = S_COLLECT;
         end
      endcase
      push_char = use_lookup ? lk[7:0] : 8'h20;
   end

   // A push into a full FIFO still lands when the head leaves in the same cycle.
   assign pop     = bus.out_ready && (fifo_count != '0);
   assign push_ok = push && ((fifo_count != CW'(FIFO_DEPTH)) || pop);
   assign drop    = push && !push_ok;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_COLLECT;
         len         <= '0;
         sym         <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_count  <= '0;
         err_unknown <= 1'b0;
         ovf_err     <= 1'b0;
      end else begin
         state <= nxt_state;
         if (clr_sym) begin
            len <= '0;
            sym <= '0;
         end else if (elem) begin
            len <= len_sat_inc(len);
            sym <= {sym[MAX_ELEMS-2:0], bus.in_code == 3'b010};
         end
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop)     rd_ptr <= rd_ptr + PW'(1);
         fifo_count  <= fifo_count + CW'(push_ok) - CW'(pop);
         err_unknown <= illegal || unk_char;
         ovf_err     <= (ovf_err && !clr_err) || drop;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_char;
   end

   assign bus.out_valid = fifo_count != '0;
   assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : 8'h00;

endmodule
